cordic_atan2_top: RTL and testbench

CORDIC_ATAN2_TOP -- requirements
Module: cordic_atan2_top

---
 rtl/cordic_atan2_top.sv | 160 ++++++++++++++++
 tb/tb_cordic_atan2_top.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/cordic_atan2_top.sv
// CORDIC vectoring unit computing atan2(y, x) in degrees.
// Q1.15 operands are folded into the right half-plane, rotated towards the
// x axis for ITER iterations while the applied angles accumulate in z
// (Q16.16 degrees), and z is then converted to an IEEE-754 single.
module cordic_atan2_top #(
  parameter int ITER = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] x_q15,
  input  logic [15:0] y_q15,
  output logic [31:0] angle_ieee754,
  output logic        valid,
  output logic        busy
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREP,
    ST_ITER,
    ST_CONV,
    ST_DONE
  } state_t;

  localparam logic [4:0]         I_LAST  = 5'(ITER - 1);
  localparam logic signed [31:0] Z_P180  = 32'sh00B4_0000;  // +180.0 in Q16.16
  localparam logic signed [31:0] Z_M180  = -32'sh00B4_0000; // -180.0 in Q16.16

  state_t             state, state_nxt;
  logic signed [17:0] x_r, y_r;
  logic signed [31:0] z_r;
  logic [4:0]         i_r;
  logic               zero_r;
  logic [31:0]        conv_r;

  logic [31:0]        mag;
  logic [4:0]         msb;
  logic [22:0]        frac;
  logic [7:0]         expo;
  logic [31:0]        flt;

  // atan(2^-i) in degrees, Q16.16, rounded to nearest.
  function automatic logic signed [31:0] atan_entry(input logic [4:0] idx);
    case (idx)
      5'd0:    atan_entry = 32'sh002D_0000;
      5'd1:    atan_entry = 32'sh001A_90A7;
      5'd2:    atan_entry = 32'sh000E_0947;
      5'd3:    atan_entry = 32'sh0007_2001;
      5'd4:    atan_entry = 32'sh0003_938B;
      5'd5:    atan_entry = 32'sh0001_CA38;
      5'd6:    atan_entry = 32'sh0000_E52A;
      5'd7:    atan_entry = 32'sh0000_7297;
      5'd8:    atan_entry = 32'sh0000_394C;
      5'd9:    atan_entry = 32'sh0000_1CA6;
      5'd10:   atan_entry = 32'sh0000_0E53;
      5'd11:   atan_entry = 32'sh0000_0729;
      5'd12:   atan_entry = 32'sh0000_0395;
      5'd13:   atan_entry = 32'sh0000_01CA;
      5'd14:   atan_entry = 32'sh0000_00E5;
      5'd15:   atan_entry = 32'sh0000_0073;
      default: atan_entry = 32'sh0000_0000;
    endcase
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking '<=' so every flop samples the
    // pre-edge values; blocking '=' here would create order-dependent races.
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; start is only looked at in IDLE.
  always_comb begin
    // NOTE: defaulting every combinational output first means no path leaves
    // it unassigned, so no latch is inferred.
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_PREP;
      ST_PREP: state_nxt = ST_ITER;
      ST_ITER: if (i_r == I_LAST) state_nxt = ST_CONV;
      ST_CONV: state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign busy = (state != ST_IDLE);

  // Fixed-point z to float: leading-one detect, truncated mantissa.
  always_comb begin
    mag  = z_r[31] ? $unsigned(-z_r) : $unsigned(z_r);
    msb  = 5'd0;
    for (int b = 0; b < 32; b++) begin
      if (mag[b]) msb = 5'(b);
    end
    if (msb >= 5'd23) frac = 23'(mag >> (msb - 5'd23));
    else              frac = 23'(mag << (5'd23 - msb));
    expo = 8'(8'd111 + {3'b000, msb});
    if (mag == 32'd0) flt = 32'h0000_0000;
    else              flt = {z_r[31], expo, frac};
  end

  // Datapath: operand capture, quadrant fold, micro-rotations, result.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_r           <= '0;
      y_r           <= '0;
      z_r           <= '0;
      i_r           <= '0;
      zero_r        <= 1'b0;
      conv_r        <= '0;
      angle_ieee754 <= '0;
      valid         <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            x_r    <= {{2{x_q15[15]}}, x_q15};
            y_r    <= {{2{y_q15[15]}}, y_q15};
            zero_r <= (x_q15 == 16'd0) && (y_q15 == 16'd0);
          end
        end
        ST_PREP: begin
          i_r <= '0;
          if (x_r[17]) begin
            // 18-bit width lets -(-32768) be represented exactly.
            x_r <= -x_r;
            y_r <= -y_r;
            z_r <= y_r[17] ? Z_M180 : Z_P180;
          end else begin
            z_r <= '0;
          end
        end
        ST_ITER: begin
          if (!y_r[17]) begin
            x_r <= x_r + (y_r >>> i_r);
            y_r <= y_r - (x_r >>> i_r);
            z_r <= z_r + atan_entry(i_r);
          end else begin
            x_r <= x_r - (y_r >>> i_r);
            y_r <= y_r + (x_r >>> i_r);
            z_r <= z_r - atan_entry(i_r);
          end
          i_r <= 5'(i_r + 5'd1);
        end
        ST_CONV: conv_r <= flt;
        ST_DONE: begin
          // A zero vector has no defined angle; report +0.0.
          angle_ieee754 <= zero_r ? 32'h0000_0000 : conv_r;
          valid         <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_atan2_top.sv
// Self-checking bench for cordic_atan2_top: a cycle-level model of the
// request/response timing plus a real-valued atan2 reference for the angle.
module tb_cordic_atan2_top;

  localparam int  ITER    = 16;
  localparam int  LAT     = ITER + 3;
  localparam real TOL     = 0.01;
  localparam real RAD2DEG = 57.29577951308232;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] x_q15 = 16'd0;
  logic [15:0] y_q15 = 16'd0;
  logic [31:0] angle_ieee754;
  logic        valid;
  logic        busy;

  int tests  = 0;
  int failed = 0;

  cordic_atan2_top #(.ITER(ITER)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .x_q15         (x_q15),
    .y_q15         (y_q15),
    .angle_ieee754 (angle_ieee754),
    .valid         (valid),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input bit ok, input string detail);
    tests++;
    if (!ok) begin
      failed++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  function automatic real f2r(input logic [31:0] b);
    real m;
    int  e;
    if (b[30:0] == 31'd0) return 0.0;
    m = $itor({1'b1, b[22:0]});
    e = int'(b[30:23]) - 150;
    if (e > 0) for (int k = 0; k < e; k++) m = m * 2.0;
    else       for (int k = 0; k < -e; k++) m = m / 2.0;
    return b[31] ? -m : m;
  endfunction

  function automatic real ref_deg(input logic [15:0] x, input logic [15:0] y);
    real xr, yr;
    xr = $itor($signed(x));
    yr = $itor($signed(y));
    return $atan2(yr, xr) * RAD2DEG;
  endfunction

  function automatic real ang_err(input real a, input real b);
    real d;
    d = a - b;
    if (d > 180.0)  d = d - 360.0;
    if (d < -180.0) d = d + 360.0;
    return (d < 0.0) ? -d : d;
  endfunction

  // ---------------- behavioural model + per-cycle compare ----------------
  bit  m_busy    = 1'b0;
  int  m_cnt     = 0;
  bit  m_valid   = 1'b0;
  bit  cur_exact = 1'b1;   // expected output is exactly 0x00000000
  real cur_deg   = 0.0;
  bit  pend_exact;
  real pend_deg;

  initial begin
    forever begin
      @(posedge clk);
      m_valid = 1'b0;
      if (rst) begin
        m_busy    = 1'b0;
        m_cnt     = 0;
        cur_exact = 1'b1;
        cur_deg   = 0.0;
      end else if (m_busy) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_busy    = 1'b0;
          m_valid   = 1'b1;
          cur_exact = pend_exact;
          cur_deg   = pend_deg;
        end
      end else if (start) begin
        m_busy     = 1'b1;
        m_cnt      = LAT;
        pend_exact = (x_q15 == 16'd0) && (y_q15 == 16'd0);
        pend_deg   = pend_exact ? 0.0 : ref_deg(x_q15, y_q15);
      end
      #1;
      check("valid", valid == m_valid, $sformatf("got %0b want %0b", valid, m_valid));
      check("busy", busy == m_busy, $sformatf("got %0b want %0b", busy, m_busy));
      if (cur_exact)
        check("angle_word", angle_ieee754 == 32'h0,
              $sformatf("got %08h want 00000000", angle_ieee754));
      else
        check("angle_deg", ang_err(f2r(angle_ieee754), cur_deg) <= TOL,
              $sformatf("got %08h (%f deg) want %f deg", angle_ieee754,
                        f2r(angle_ieee754), cur_deg));
    end
  end

  // ---------------- stimulus ----------------
  // Issue one request, optionally pulse start again while busy, then wait
  // for valid and compare against a literal expectation.
  task automatic run_op(input string name, input logic [15:0] x, input logic [15:0] y,
                        input bit use_lit, input real lit_deg, input bit lit_mag,
                        input int glitch_at);
    bit  got;
    real r;
    @(negedge clk);
    x_q15 = x; y_q15 = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (glitch_at > 0) begin
      repeat (glitch_at) @(negedge clk);
      x_q15 = 16'(~x); y_q15 = 16'($urandom); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(posedge clk);
      #1;
      if (valid) got = 1'b1;
    end
    check({name, "_timeout"}, got, "valid not seen within 40 cycles");
    if (got && use_lit) begin
      r = f2r(angle_ieee754);
      if (lit_mag) r = (r < 0.0) ? -r : r;
      check(name, ang_err(r, lit_deg) <= TOL,
            $sformatf("got %08h (%f deg) want %f deg", angle_ieee754, r, lit_deg));
    end
  endtask

  initial begin
    logic [15:0] rx, ry;
    int          ax, ay;

    // Pin the reference helpers with hand-computed values.
    check("pin_f2r_45", f2r(32'h4234_0000) == 45.0, $sformatf("got %f want 45.0", f2r(32'h4234_0000)));
    check("pin_f2r_m135", f2r(32'hC307_0000) == -135.0, $sformatf("got %f want -135.0", f2r(32'hC307_0000)));
    check("pin_ref_45", ang_err(ref_deg(16'h5A82, 16'h5A82), 45.0) <= 1e-6,
          $sformatf("got %f want 45.0", ref_deg(16'h5A82, 16'h5A82)));
    check("pin_ref_m135", ang_err(ref_deg(16'hA57E, 16'hA57E), -135.0) <= 1e-6,
          $sformatf("got %f want -135.0", ref_deg(16'hA57E, 16'hA57E)));

    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_angle", angle_ieee754 == 32'h0, $sformatf("got %08h want 00000000", angle_ieee754));
    check("reset_busy", busy == 1'b0, $sformatf("got %0b want 0", busy));

    // Directed cases; each follows the previous valid immediately.
    run_op("zero_deg", 16'h7FFF, 16'h0000, 1, 0.0,    0, 0);
    run_op("q1_45",    16'h5A82, 16'h5A82, 1, 45.0,   0, 0);
    run_op("pos_90",   16'h0000, 16'h7FFF, 1, 90.0,   0, 0);
    run_op("q3_m135",  16'hA57E, 16'hA57E, 1, -135.0, 0, 0);
    run_op("neg_x180", 16'h8000, 16'h0000, 1, 180.0,  1, 0);
    run_op("both_zero", 16'h0000, 16'h0000, 0, 0.0,   0, 0);
    check("both_zero_word", angle_ieee754 == 32'h0, $sformatf("got %08h want 00000000", angle_ieee754));
    run_op("ignore_2nd", 16'h7FFF, 16'h7FFF, 1, 45.0, 0, 4);

    // Reset in flight: start at N, rst sampled at N+8.
    @(negedge clk);
    x_q15 = 16'h4000; y_q15 = 16'h2000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    check("abort_busy", busy == 1'b0, $sformatf("got %0b want 0", busy));
    check("abort_angle", angle_ieee754 == 32'h0, $sformatf("got %08h want 00000000", angle_ieee754));
    run_op("after_reset", 16'h0000, 16'h8000, 1, -90.0, 0, 0);

    // Randomised vectors, large enough that the 0.01 degree bound applies.
    for (int t = 0; t < 40; t++) begin
      do begin
        rx = 16'($urandom);
        ry = 16'($urandom);
        ax = $signed(rx); ay = $signed(ry);
        if (ax < 0) ax = -ax;
        if (ay < 0) ay = -ay;
      end while (ax < 20000 && ay < 20000);
      run_op("rand", rx, ry, 0, 0.0, 0, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 12)) : 0);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 5)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
